jogador_automatico: RTL and testbench
=====================================

# jogador_automatico

Automatic player for jogo_playseq: watches the game's `leds` output while a sequence is being shown, stores each displayed term, and replays the stored terms on the game's `botoes` input with fixed press and release durations. It sits beside jogo_playseq on the same clock as the other end of the LED/button interface, for hands-free demos and long regression runs of the game.

## Interface
- `PRESS_CYCLES`, 25000: cycles each button is held (0.5 s at 50 kHz).
- `GAP_CYCLES`, 25000: cycles of all-released buttons after each press.
- `QUIET_CYCLES`, 75000: consecutive dark-LED cycles that end the show phase.
- `DEPTH`, 16: maximum stored terms (≤16).

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `habilita`  in  1  enable; 0 forces OCIOSO.
- `leds`  in  4  game LED outputs; one-hot or 0000.
- `botoes`  out  4  button drive to game, registered.
- `jogando`  out  1  high in PRESSIONA/SOLTA.
- `num_termos`  out  5  terms captured this round, 0..16.
- `erro`  out  1  high in ERRO.
- `db_estado`  out  3  state code.

## Operation
- States and codes: OCIOSO=0, OBSERVA=1, PRESSIONA=2, SOLTA=3, ERRO=7.
- `leds_prev` register updated from `leds` every cycle in every state. A term edge is `leds_prev==0000 && leds!=0000`.
- OCIOSO: `botoes`=0, count=0, idx=0. `habilita`=1 → OBSERVA.
- OBSERVA:
  - Term edge with one-hot `leds` and count<DEPTH: mem[count]←`leds`, count+1.
  - Term edge with count==DEPTH → ERRO.
  - `leds` nonzero and not one-hot, at any cycle → ERRO.
  - Quiet counter increments on each cycle with `leds`==0000 and clears on any nonzero cycle.
  - Quiet counter reaching QUIET_CYCLES with count>0 → PRESSIONA, idx=0.
  - With count==0, the counter saturates and the state holds.
- PRESSIONA: `botoes`=mem[idx] for PRESS_CYCLES cycles → SOLTA.
- SOLTA: `botoes`=0 for GAP_CYCLES cycles, then idx+1.
  - idx+1==count → OBSERVA, count←0, quiet counter←0.
  - Otherwise → PRESSIONA.
- `leds` are ignored in PRESSIONA and SOLTA, so game echoes are not captured.
- ERRO: `botoes`=0. The state holds until `habilita`=0, then → OCIOSO.
- `habilita`=0 in any state → OCIOSO on the next edge, with `botoes` cleared that same edge. This has priority over all other transitions.
- Mid-operation `reset` assertion clears everything immediately.

## Timing
- Reset values: `botoes`=0000, `jogando`=0, `num_termos`=0, `erro`=0, `db_estado`=0, `leds_prev`=0000, and all counters and mem index 0. Mem contents need no reset.
- Capture latency: `num_termos` increments at the edge that samples the term edge, visible 1 cycle later.
- A lit LED held for any duration counts once. Back-to-back terms without a dark cycle between them are a single term. The game guarantees ≥1 dark cycle between terms.
- The last term sampled dark at cycle t starts the quiet count. `botoes` goes to mem[0] QUIET_CYCLES cycles after t, loaded at the state-change edge.
- Each term occupies exactly PRESS_CYCLES cycles of nonzero `botoes` followed by GAP_CYCLES cycles of zero. No skew between `botoes` and `jogando` (both registered).
- The round ends the cycle after the last gap completes. OBSERVA resumes with `num_termos`=0.

## Test plan
Bench parameters: PRESS_CYCLES=4, GAP_CYCLES=3, QUIET_CYCLES=10, DEPTH=16.

1. Reset: drive `reset`=0 mid-PRESSIONA → same cycle `botoes`=0000, `jogando`=0, `num_termos`=0, `db_estado`=0.
2. Capture and replay: `habilita`=1; show 0001, 0010, 1000, each lit 5 cycles with 2 dark cycles between; then dark.
   - `num_termos` goes to 3.
   - 10 cycles after the last dark sample, `botoes` = 0001×4, 0000×3, 0010×4, 0000×3, 1000×4, 0000×3.
   - Then `db_estado`=1 and `num_termos`=0.
3. Invalid LEDs: in OBSERVA, `leds`=0011 for 1 cycle → `erro`=1, `db_estado`=7, `botoes`=0000. Then `habilita`=0 → OCIOSO, `erro`=0.
4. Overflow: show 17 one-hot terms → `num_termos`=16 after the 16th, ERRO on the 17th edge, no replay.
5. Long light / empty quiet:
   - `leds`=0100 held 40 cycles → `num_termos`=1 only, no transition while lit.
   - With 0 terms captured, 30 dark cycles → remains in OBSERVA.
6. Disable mid-replay: `habilita`→0 during the second PRESSIONA → next edge `botoes`=0000 and `db_estado`=0. Re-enabling starts a fresh OBSERVA with `num_termos`=0.

Source files
------------

// File: rtl/jogador_automatico_if.sv
// LED/button link between the game and the automatic player.
interface jogador_automatico_if;
  logic [3:0] leds;
  logic [3:0] botoes;

  // Player side: watches the game's LEDs, drives the game's buttons.
  modport master (
    input  leds,
    output botoes
  );

  // Game side: drives LEDs, receives button presses.
  modport slave (
    output leds,
    input  botoes
  );
endinterface

// File: rtl/jogador_automatico.sv
// Automatic player: records the LED terms shown by the game, then replays
// them on the buttons with fixed press and release durations.
module jogador_automatico #(
  parameter int unsigned PRESS_CYCLES = 25000,
  parameter int unsigned GAP_CYCLES   = 25000,
  parameter int unsigned QUIET_CYCLES = 75000,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        habilita,
  jogador_automatico_if.master        jogo,
  output logic                        jogando,
  output logic [4:0]                  num_termos,
  output logic                        erro,
  output logic [2:0]                  db_estado
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TMR_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned QUI_W   = $clog2(QUIET_CYCLES + 1);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    OBSERVA   = 3'd1,
    PRESSIONA = 3'd2,
    SOLTA     = 3'd3,
    ERRO      = 3'd7
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [3:0]         leds_prev_q;
  logic [4:0]         count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [QUI_W-1:0]   quiet_q, quiet_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [3:0]         botoes_q, botoes_d;
  logic               jogando_q, jogando_d;
  logic               erro_q, erro_d;
  logic [3:0]         mem [DEPTH];

  logic               one_hot_c;
  logic               invalid_c;
  logic               term_edge_c;
  logic               last_term_c;
  logic               quiet_full_c;
  logic               capture_c;

  // LED pattern classification against the previous sample.
  always_comb begin
    one_hot_c    = (jogo.leds != 4'd0) && ((jogo.leds & (jogo.leds - 4'd1)) == 4'd0);
    invalid_c    = (jogo.leds != 4'd0) && !one_hot_c;
    term_edge_c  = (leds_prev_q == 4'd0) && (jogo.leds != 4'd0);
    last_term_c  = ((5'(idx_q) + 5'd1) == count_q);
    quiet_full_c = (quiet_q == QUI_W'(QUIET_CYCLES));
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      leds_prev_q <= 4'd0;
      count_q     <= 5'd0;
      idx_q       <= '0;
      quiet_q     <= '0;
      timer_q     <= '0;
      botoes_q    <= 4'd0;
      jogando_q   <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      leds_prev_q <= jogo.leds;
      count_q     <= count_d;
      idx_q       <= idx_d;
      quiet_q     <= quiet_d;
      timer_q     <= timer_d;
      botoes_q    <= botoes_d;
      jogando_q   <= jogando_d;
      erro_q      <= erro_d;
    end
  end

  // Term storage; contents are only meaningful below count_q.
  always_ff @(posedge clock) begin
    if (capture_c) begin
      mem[count_q[IDX_W-1:0]] <= jogo.leds;
    end
  end

  // Next-state logic; disable overrides every other transition.
  always_comb begin
    estado_d  = estado_q;
    count_d   = count_q;
    idx_d     = idx_q;
    quiet_d   = quiet_q;
    timer_d   = timer_q;
    capture_c = 1'b0;

    if (!habilita) begin
      estado_d = OCIOSO;
      count_d  = 5'd0;
      idx_d    = '0;
      quiet_d  = '0;
      timer_d  = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          count_d  = 5'd0;
          idx_d    = '0;
          quiet_d  = '0;
          timer_d  = '0;
          estado_d = OBSERVA;
        end

        OBSERVA: begin
          // Count consecutive dark samples, saturating once the quiet time is met.
          if (jogo.leds == 4'd0) begin
            quiet_d = quiet_full_c ? quiet_q : quiet_q + QUI_W'(1);
          end else begin
            quiet_d = '0;
          end

          if (invalid_c) begin
            estado_d = ERRO;
          end else if (term_edge_c) begin
            if (count_q == 5'(DEPTH)) begin
              estado_d = ERRO;
            end else begin
              capture_c = 1'b1;
              count_d   = count_q + 5'd1;
            end
          end else if (quiet_full_c && (count_q != 5'd0)) begin
            estado_d = PRESSIONA;
            idx_d    = '0;
            timer_d  = '0;
            quiet_d  = '0;
          end
        end

        PRESSIONA: begin
          if (timer_q == TMR_W'(PRESS_CYCLES - 1)) begin
            estado_d = SOLTA;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end

        SOLTA: begin
          if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
            timer_d = '0;
            if (last_term_c) begin
              estado_d = OBSERVA;
              count_d  = 5'd0;
              idx_d    = '0;
              quiet_d  = '0;
            end else begin
              estado_d = PRESSIONA;
              idx_d    = idx_q + IDX_W'(1);
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end

        ERRO: begin
          estado_d = ERRO;
        end

        default: begin
          estado_d = OCIOSO;
        end
      endcase
    end
  end

  // Output values decoded from the next state so they register with it.
  always_comb begin
    botoes_d  = 4'd0;
    jogando_d = 1'b0;
    erro_d    = 1'b0;
    if (estado_d == PRESSIONA) begin
      botoes_d = mem[idx_d];
    end
    if ((estado_d == PRESSIONA) || (estado_d == SOLTA)) begin
      jogando_d = 1'b1;
    end
    if (estado_d == ERRO) begin
      erro_d = 1'b1;
    end
  end

  assign jogo.botoes = botoes_q;
  assign jogando     = jogando_q;
  assign erro        = erro_q;
  assign num_termos  = count_q;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for the automatic player: stimulus pushes the expected
// button stream, a negedge monitor pops and compares it.
module tb_jogador_automatico;

  localparam int P = 4;
  localparam int G = 3;
  localparam int Q = 10;
  localparam int D = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic       jogando;
  logic [4:0] num_termos;
  logic       erro;
  logic [2:0] db_estado;

  jogador_automatico_if bus ();

  jogador_automatico #(
    .PRESS_CYCLES(P),
    .GAP_CYCLES  (G),
    .QUIET_CYCLES(Q),
    .DEPTH       (D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .habilita  (habilita),
    .jogo      (bus),
    .jogando   (jogando),
    .num_termos(num_termos),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t       exp_q [$];
  logic [3:0] shown [$];
  exp_t       mon_e;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle the player is pressing or replaying must match the queue.
  always @(negedge clock) begin
    if (reset && (jogando || (bus.botoes != 4'd0))) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL replay_unexpected: got botoes=%b jogando=%b with nothing expected (cycle %0d)",
                 bus.botoes, jogando, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("replay_cycle", cyc, mon_e.cyc);
        chk("replay_botoes", int'(bus.botoes), int'(mon_e.val));
      end
    end
  end

  task automatic tick(input logic [3:0] v);
    bus.leds = v;
    @(posedge clock);
    #1;
  endtask

  // One shown term: lit for 'lit' cycles, then 'dark' dark cycles.
  task automatic show_term(input logic [3:0] v, input int lit, input int dark, output int t_dark);
    shown.push_back(v);
    tick(v);
    chk("num_termos_capture", int'(num_termos), shown.size());
    for (int i = 1; i < lit; i++) tick(v);
    chk("db_observa", int'(db_estado), 1);
    tick(4'd0);
    t_dark = cyc;
    for (int i = 1; i < dark; i++) tick(4'd0);
  endtask

  // Expected stream: each term P cycles pressed then G released, starting Q after t.
  task automatic expect_replay(input int t, input int n_cycles);
    int base;
    int k;
    base = t + Q;
    k = 0;
    foreach (shown[i]) begin
      for (int j = 0; j < P; j++) begin
        if (k < n_cycles) exp_q.push_back('{cyc: base + i * (P + G) + j, val: shown[i]});
        k++;
      end
      for (int j = 0; j < G; j++) begin
        if (k < n_cycles) exp_q.push_back('{cyc: base + i * (P + G) + P + j, val: 4'd0});
        k++;
      end
    end
  endtask

  // Full replay with the game echoing the buttons onto its LEDs.
  task automatic run_replay(input int t);
    int e_end;
    int guard;
    e_end = t + Q + shown.size() * (P + G);
    expect_replay(t, 1 << 20);
    guard = 0;
    while (cyc < e_end && guard < 2000) begin
      tick(bus.botoes);
      guard++;
    end
    chk("replay_end_cycle", cyc, e_end);
    chk("end_db_observa", int'(db_estado), 1);
    chk("end_num_termos", int'(num_termos), 0);
    chk("end_jogando", int'(jogando), 0);
    chk("end_queue_drained", exp_q.size(), 0);
    shown.delete();
  endtask

  initial begin
    int         t;
    int         n;
    int         guard;
    logic [3:0] v;

    reset    = 1'b1;
    habilita = 1'b0;
    bus.leds = 4'd0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_botoes", int'(bus.botoes), 0);
    chk("rst_jogando", int'(jogando), 0);
    chk("rst_num_termos", int'(num_termos), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_db_estado", int'(db_estado), 0);
    reset = 1'b1;
    tick(4'd0);
    chk("idle_db_estado", int'(db_estado), 0);

    // Directed capture and replay of 0001, 0010, 1000.
    habilita = 1'b1;
    tick(4'd0);
    chk("enter_observa", int'(db_estado), 1);
    show_term(4'b0001, 5, 2, t);
    show_term(4'b0010, 5, 2, t);
    show_term(4'b1000, 5, 1, t);
    chk("three_terms", int'(num_termos), 3);
    run_replay(t);

    // Random rounds.
    repeat (4) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        v = 4'b0001 << $urandom_range(0, 3);
        show_term(v, $urandom_range(1, 6), (k < n - 1) ? $urandom_range(1, 3) : 1, t);
      end
      run_replay(t);
    end

    // Long light counts once and never starts the quiet timer.
    shown.push_back(4'b0100);
    tick(4'b0100);
    chk("long_capture", int'(num_termos), 1);
    for (int i = 1; i < 40; i++) begin
      tick(4'b0100);
      chk("long_db_observa", int'(db_estado), 1);
    end
    chk("long_num_termos", int'(num_termos), 1);
    tick(4'd0);
    t = cyc;
    run_replay(t);

    // Invalid LED patterns: fixed 0011, then random with a term already stored.
    for (int it = 0; it < 2; it++) begin
      if (it == 0) begin
        v = 4'b0011;
      end else begin
        show_term(4'b0010, 2, 1, t);
        do v = 4'($urandom_range(3, 15)); while ((v & (v - 4'd1)) == 4'd0);
      end
      tick(v);
      chk("inv_erro", int'(erro), 1);
      chk("inv_db_estado", int'(db_estado), 7);
      chk("inv_botoes", int'(bus.botoes), 0);
      repeat (15) tick(4'd0);
      chk("inv_hold", int'(db_estado), 7);
      habilita = 1'b0;
      tick(4'd0);
      chk("inv_exit_db", int'(db_estado), 0);
      chk("inv_exit_erro", int'(erro), 0);
      shown.delete();
      habilita = 1'b1;
      tick(4'd0);
    end

    // Quiet with nothing captured stays in OBSERVA.
    repeat (30) tick(4'd0);
    chk("empty_db_observa", int'(db_estado), 1);
    chk("empty_num_termos", int'(num_termos), 0);
    chk("empty_jogando", int'(jogando), 0);

    // Overflow: 16 terms fit, the 17th edge is an error.
    for (int k = 0; k < D; k++) begin
      v = 4'b0001 << $urandom_range(0, 3);
      show_term(v, $urandom_range(1, 2), 1, t);
    end
    chk("ovf_num_termos", int'(num_termos), 16);
    tick(4'b0001);
    chk("ovf_db_estado", int'(db_estado), 7);
    chk("ovf_erro", int'(erro), 1);
    repeat (20) tick(4'd0);
    chk("ovf_hold", int'(db_estado), 7);
    chk("ovf_no_replay", int'(jogando), 0);
    habilita = 1'b0;
    tick(4'd0);
    chk("ovf_exit_db", int'(db_estado), 0);
    shown.delete();
    habilita = 1'b1;
    tick(4'd0);

    // Disable during the second press.
    show_term(4'b1000, 3, 2, t);
    show_term(4'b0100, 3, 1, t);
    expect_replay(t, P + G + 2);
    guard = 0;
    while (cyc < t + Q + P + G + 1 && guard < 200) begin
      tick(bus.botoes);
      guard++;
    end
    habilita = 1'b0;
    tick(4'd0);
    chk("dis_botoes", int'(bus.botoes), 0);
    chk("dis_db_estado", int'(db_estado), 0);
    chk("dis_jogando", int'(jogando), 0);
    chk("dis_queue_drained", exp_q.size(), 0);
    shown.delete();
    habilita = 1'b1;
    tick(4'd0);
    chk("reen_db_estado", int'(db_estado), 1);
    chk("reen_num_termos", int'(num_termos), 0);

    // Asynchronous reset in the middle of a press.
    v = 4'b0001 << $urandom_range(0, 3);
    show_term(v, 2, 1, t);
    expect_replay(t, 1);
    guard = 0;
    while (cyc < t + Q + 1 && guard < 200) begin
      tick(4'd0);
      guard++;
    end
    #1 reset = 1'b0;
    #1;
    chk("arst_botoes", int'(bus.botoes), 0);
    chk("arst_jogando", int'(jogando), 0);
    chk("arst_num_termos", int'(num_termos), 0);
    chk("arst_db_estado", int'(db_estado), 0);
    chk("arst_erro", int'(erro), 0);
    #1 reset = 1'b1;
    shown.delete();
    tick(4'd0);
    chk("arst_restart_db", int'(db_estado), 1);
    chk("arst_restart_num", int'(num_termos), 0);
    repeat (3) tick(4'd0);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
